fizzbuzz_checker: RTL and testbench

//  Receive-side checker for the fizzbuzz stream: consumes {number, is_fizz, is_buzz} beats and

---
 rtl/fizzbuzz_pkg.sv | 15 +
 rtl/fizzbuzz_mod_counter.sv | 27 ++
 rtl/fizzbuzz_checker.sv | 129 ++++++++++++
 tb/tb_fizzbuzz_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the fizzbuzz stream checker.
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        FAIL   = 2'd2
    } chk_state_t;

    // Bit positions inside the 3-bit error code.
    localparam int ERR_NUM  = 2;
    localparam int ERR_FIZZ = 1;
    localparam int ERR_BUZZ = 0;

endpackage

// File: rtl/fizzbuzz_mod_counter.sv
// Residue counter modulo g_mod: loadable, advances by one and wraps at g_mod-1.
module fizzbuzz_mod_counter #(
    parameter int g_mod = 3,
    localparam int W = $clog2(g_mod)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         advance,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] LAST = W'(g_mod - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (advance) begin
            value <= (value == LAST) ? '0 : value + ONE;
        end
    end

endmodule

// File: rtl/fizzbuzz_checker.sv
// Sink-side checker: locks onto the 0..g_length fizzbuzz stream and reports mismatching beats.
module fizzbuzz_checker
    import fizzbuzz_pkg::*;
#(
    parameter int g_length = 50,
    parameter int g_resync = 1,
    parameter int g_cnt_w  = 16,
    localparam int NUM_W = $clog2(g_length + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [NUM_W-1:0]   i_number,
    input  logic               i_is_fizz,
    input  logic               i_is_buzz,
    output logic               o_locked,
    output logic               o_err,
    output logic [2:0]         o_err_code,
    output logic               o_err_sticky,
    output logic [g_cnt_w-1:0] o_err_cnt,
    output logic [g_cnt_w-1:0] o_period_cnt
);

    localparam logic [NUM_W-1:0]   NUM_LAST = NUM_W'(g_length);
    localparam logic [NUM_W-1:0]   NUM_ONE  = NUM_W'(1);
    localparam logic [g_cnt_w-1:0] CNT_ONE  = g_cnt_w'(1);

    chk_state_t       state_q, state_d;
    logic [NUM_W-1:0] exp_num;
    logic [1:0]       r3;
    logic [2:0]       r5;
    logic             beat, lock_beat, track_beat, err_beat, match_beat, at_last;
    logic             exp_fizz, exp_buzz;
    logic [2:0]       code;

    // A beat coinciding with i_clear is discarded.
    assign beat       = i_valid && !i_clear;
    assign exp_fizz   = (exp_num != '0) && (r3 == '0);
    assign exp_buzz   = (exp_num != '0) && (r5 == '0);
    assign at_last    = (exp_num == NUM_LAST);

    always_comb begin
        code           = '0;
        code[ERR_NUM]  = (i_number != exp_num);
        code[ERR_FIZZ] = (i_is_fizz != exp_fizz);
        code[ERR_BUZZ] = (i_is_buzz != exp_buzz);
    end

    assign lock_beat  = beat && (state_q == SEARCH) && (i_number == '0) && !i_is_fizz && !i_is_buzz;
    assign track_beat = beat && (state_q == TRACK);
    assign err_beat   = track_beat && (code != '0);
    assign match_beat = track_beat && (code == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= SEARCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH:  if (lock_beat) state_d = TRACK;
                TRACK:   if (err_beat)  state_d = (g_resync != 0) ? SEARCH : FAIL;
                FAIL:    state_d = FAIL;
                default: state_d = SEARCH;
            endcase
        end
    end

    assign o_locked = (state_q == TRACK);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear)  exp_num <= '0;
        else if (lock_beat)    exp_num <= NUM_ONE;
        else if (match_beat)   exp_num <= at_last ? '0 : exp_num + NUM_ONE;
    end

    // Residues follow exp_num: reloaded on lock, clear and period wrap.
    logic res_load, res_adv;
    assign res_load = i_clear || lock_beat || (match_beat && at_last);
    assign res_adv  = match_beat && !at_last;

    fizzbuzz_mod_counter #(.g_mod(3)) u_mod3 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (res_load),
        .load_val (lock_beat ? 2'd1 : 2'd0),
        .advance  (res_adv),
        .value    (r3)
    );

    fizzbuzz_mod_counter #(.g_mod(5)) u_mod5 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (res_load),
        .load_val (lock_beat ? 3'd1 : 3'd0),
        .advance  (res_adv),
        .value    (r5)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err        <= 1'b0;
            o_err_code   <= '0;
            o_err_sticky <= 1'b0;
            o_err_cnt    <= '0;
            o_period_cnt <= '0;
        end else begin
            o_err <= err_beat;
            if (err_beat) o_err_code <= code;
            if (i_clear) begin
                o_err_sticky <= 1'b0;
                o_err_cnt    <= '0;
                o_period_cnt <= '0;
            end else begin
                if (err_beat) begin
                    o_err_sticky <= 1'b1;
                    if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_ONE;
                end
                if (match_beat && at_last) o_period_cnt <= o_period_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fizzbuzz_checker.sv
// Bench for fizzbuzz_checker: three instances (resync / no-resync / 4-bit counters) on one stream.
module tb_fizzbuzz_checker;

    localparam int L = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] num = '0;
    logic       fz = 1'b0;
    logic       bz = 1'b0;

    logic a_locked, a_err, a_sticky, b_locked, b_err, b_sticky, c_locked, c_err, c_sticky;
    logic [2:0]  a_code, b_code, c_code;
    logic [15:0] a_ecnt, a_pcnt, b_ecnt, b_pcnt;
    logic [3:0]  c_ecnt, c_pcnt;

    fizzbuzz_checker #(.g_length(L), .g_resync(1), .g_cnt_w(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid), .i_number(num),
        .i_is_fizz(fz), .i_is_buzz(bz), .o_locked(a_locked), .o_err(a_err), .o_err_code(a_code),
        .o_err_sticky(a_sticky), .o_err_cnt(a_ecnt), .o_period_cnt(a_pcnt));

    fizzbuzz_checker #(.g_length(L), .g_resync(0), .g_cnt_w(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid), .i_number(num),
        .i_is_fizz(fz), .i_is_buzz(bz), .o_locked(b_locked), .o_err(b_err), .o_err_code(b_code),
        .o_err_sticky(b_sticky), .o_err_cnt(b_ecnt), .o_period_cnt(b_pcnt));

    fizzbuzz_checker #(.g_length(L), .g_resync(1), .g_cnt_w(4)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid), .i_number(num),
        .i_is_fizz(fz), .i_is_buzz(bz), .o_locked(c_locked), .o_err(c_err), .o_err_code(c_code),
        .o_err_sticky(c_sticky), .o_err_cnt(c_ecnt), .o_period_cnt(c_pcnt));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int RESYNC [3] = '{1, 0, 1};
    localparam int CMOD   [3] = '{65536, 65536, 16};

    int m_lock [3] = '{0, 0, 0};
    int m_fail [3] = '{0, 0, 0};
    int m_exp  [3] = '{0, 0, 0};
    int m_err  [3] = '{0, 0, 0};
    int m_code [3] = '{0, 0, 0};
    int m_stk  [3] = '{0, 0, 0};
    int m_ecnt [3] = '{0, 0, 0};
    int m_pcnt [3] = '{0, 0, 0};

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_lock[k] = 0; m_fail[k] = 0; m_exp[k] = 0; m_err[k] = 0;
                m_code[k] = 0; m_stk[k] = 0; m_ecnt[k] = 0; m_pcnt[k] = 0;
            end else begin
                m_err[k] = 0;
                if (clear) begin
                    m_lock[k] = 0; m_fail[k] = 0; m_stk[k] = 0; m_ecnt[k] = 0; m_pcnt[k] = 0;
                end else if (valid && m_fail[k] == 0) begin
                    if (m_lock[k] == 0) begin
                        if (num == 0 && !fz && !bz) begin
                            m_lock[k] = 1;
                            m_exp[k]  = 1;
                        end
                    end else begin
                        int e;
                        int c;
                        e = m_exp[k];
                        c = ((int'(num) != e) ? 4 : 0)
                          + ((int'(fz) != int'(e != 0 && e % 3 == 0)) ? 2 : 0)
                          + ((int'(bz) != int'(e != 0 && e % 5 == 0)) ? 1 : 0);
                        if (c != 0) begin
                            m_err[k]  = 1;
                            m_code[k] = c;
                            m_stk[k]  = 1;
                            if (m_ecnt[k] < CMOD[k] - 1) m_ecnt[k]++;
                            m_lock[k] = 0;
                            m_fail[k] = (RESYNC[k] == 0) ? 1 : 0;
                        end else begin
                            if (e == L) m_pcnt[k] = (m_pcnt[k] + 1) % CMOD[k];
                            m_exp[k] = (e == L) ? 0 : e + 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic lk, input logic er, input logic [2:0] cd,
                            input logic st, input logic [15:0] ec, input logic [15:0] pc);
        chk("locked", k, 32'(lk), m_lock[k]);
        chk("err", k, 32'(er), m_err[k]);
        chk("err_code", k, 32'(cd), m_code[k]);
        chk("sticky", k, 32'(st), m_stk[k]);
        chk("err_cnt", k, 32'(ec), m_ecnt[k]);
        chk("period_cnt", k, 32'(pc), m_pcnt[k]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk_inst(0, a_locked, a_err, a_code, a_sticky, a_ecnt, a_pcnt);
            chk_inst(1, b_locked, b_err, b_code, b_sticky, b_ecnt, b_pcnt);
            chk_inst(2, c_locked, c_err, c_code, c_sticky, {12'b0, c_ecnt}, {12'b0, c_pcnt});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int n, input bit f, input bit b, input bit clr);
        @(posedge clk);
        #1;
        valid = 1'b1;
        num   = 6'(n);
        fz    = f;
        bz    = b;
        clear = clr;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) begin
            @(posedge clk);
            #1;
            valid = 1'b0;
            clear = 1'b0;
        end
    endtask

    task automatic good(input int n);
        drive(n, n != 0 && n % 3 == 0, n != 0 && n % 5 == 0, 1'b0);
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        valid = 1'b0;
        clear = 1'b1;
        idle(1);
    endtask

    task automatic period(input bit gaps);
        for (int n = 0; n <= L; n++) begin
            if (gaps) idle($urandom_range(0, 10));
            good(n);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("reset_locked", 0, 32'(a_locked), 0);
        chk("reset_err_cnt", 0, 32'(a_ecnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Two clean periods back to back.
        period(0);
        period(0);
        idle(1);
        @(negedge clk);
        chk("clean_period_cnt", 0, 32'(a_pcnt), 2);
        chk("clean_err_sticky", 0, 32'(a_sticky), 0);

        // Missing fizz at 9.
        do_clear();
        for (int n = 0; n <= 8; n++) good(n);
        drive(9, 1'b0, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("badfizz_err", 0, 32'(a_err), 1);
        chk("badfizz_code", 0, 32'(a_code), 3'b010);
        chk("badfizz_cnt", 0, 32'(a_ecnt), 1);
        chk("badfizz_locked", 0, 32'(a_locked), 0);
        for (int n = 10; n <= L; n++) good(n);
        period(0);

        // Skip 8: 7 then 9.
        do_clear();
        for (int n = 0; n <= 7; n++) good(n);
        drive(9, 1'b1, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("skip_code", 1, 32'(b_code), 3'b110);
        for (int n = 0; n <= 2; n++) good(n);
        idle(1);
        @(negedge clk);
        chk("fail_locked", 1, 32'(b_locked), 0);
        chk("fail_err_cnt", 1, 32'(b_ecnt), 1);

        // Out-of-range after the last number, then saturation.
        do_clear();
        period(0);
        drive(51, 1'b0, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("range_code", 0, 32'(a_code), 3'b100);
        for (int i = 0; i < 19; i++) begin
            good(0);
            drive(5, 1'b0, 1'b0, 1'b0);
        end
        idle(1);
        @(negedge clk);
        chk("sat_err_cnt", 2, 32'(c_ecnt), 15);
        chk("unsat_err_cnt", 0, 32'(a_ecnt), 20);

        // Clear together with a valid beat mid-track.
        for (int n = 0; n <= 20; n++) good(n);
        drive(21, 1'b1, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        chk("clear_locked", 0, 32'(a_locked), 0);
        chk("clear_err", 0, 32'(a_err), 0);
        chk("clear_err_cnt", 0, 32'(a_ecnt), 0);
        chk("clear_sticky", 0, 32'(a_sticky), 0);
        period(0);

        // Gapped clean stream.
        do_clear();
        period(1);
        period(1);
        idle(1);
        @(negedge clk);
        chk("gaps_period_cnt", 0, 32'(a_pcnt), 2);
        chk("gaps_err_cnt", 0, 32'(a_ecnt), 0);

        // Random stream with corruption, clears and gaps.
        begin
            int n;
            n = 0;
            for (int i = 0; i < 1500; i++) begin
                int r;
                int v;
                bit f;
                bit b;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 10));
                r = $urandom_range(0, 99);
                v = n;
                f = (n != 0 && n % 3 == 0);
                b = (n != 0 && n % 5 == 0);
                if (r < 3)      v = $urandom_range(0, 63);
                else if (r < 5) f = ~f;
                else if (r < 7) b = ~b;
                drive(v, f, b, r >= 98);
                if (i == 750) rst = 1'b1;
                if (i == 752) rst = 1'b0;
                n = (n == L) ? 0 : n + 1;
            end
        end
        idle(3);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
